cpri_rx_framer: RTL
===================

# cpri_rx_framer

Chip framer upstream of the CPRI receive chip buffer (`cpri_rx_gen`, write side). Takes the raw 64-bit de-mapped CPRI word stream with a start-of-chip marker and hunts for chip alignment. Each accepted chip is re-emitted as an addressed write burst, word addresses 0..CHIP_WORDS-1, with `wlast` on the final word. It also extracts FFT AGC/shift side information from the chip header and drops whole chips when the downstream buffer is full.

## Interface
Parameters:
- CHIP_WORDS, 96: 64-bit words per chip. Address width is fixed at 7, so CHIP_WORDS ≤ 128.
- SYNC_WORD, 16'hA5C3: required value of word 0 bits [63:48].
- AGC_IDX, 1: header word index carrying the FFT AGC value in bits [15:0].
- SHIFT_IDX, 2: header word index carrying the 64-bit FFT shift value.

Ports:
- wr_clk, in, 1: single clock.
- wr_rst, in, 1: reset, asynchronous, active-high.
- i_cpri_data, in, 64: raw word.
- i_cpri_vld, in, 1: word valid. Gaps are allowed anywhere.
- i_cpri_sof, in, 1: start-of-chip marker. Qualified by i_cpri_vld.
- i_tready, in, 1: downstream has space for one chip.
- o_cpri_wen, out, 1: write enable.
- o_cpri_waddr, out, 7: word address within the chip.
- o_cpri_wdata, out, 64: write data.
- o_cpri_wlast, out, 1: last word of an accepted chip.
- o_fft_agc, out, 16: AGC value of the current or last accepted chip.
- o_fft_shift, out, 64: shift value of the current or last accepted chip.
- o_lock, out, 1: alignment acquired.
- o_chip_cnt, out, 16: accepted chips, saturating.
- o_drop_cnt, out, 16: chips dropped because i_tready was low, saturating.
- o_err_cnt, out, 16: framing errors, saturating.

## Operation
- States:
  - HUNT: not aligned.
  - PASS: forwarding an accepted chip.
  - DROP: discarding a chip while aligned.
  - WAIT_SOF: chip complete, next valid word must carry sof.
- A "start" is a valid word with sof=1 and data[63:48]==SYNC_WORD.
- HUNT: on a start, go to PASS if i_tready=1, else DROP with drop_cnt+1. o_lock=1 from the next cycle. All other words are ignored.
- PASS/DROP: the word counter advances only on valid words.
  - In PASS, each valid word is written with waddr=counter.
  - On word CHIP_WORDS-1, PASS asserts wlast and increments chip_cnt. Both states then go to WAIT_SOF.
- WAIT_SOF:
  - A start re-enters PASS or DROP by the i_tready rule.
  - A valid word without sof, or sof with a sync mismatch, is an error: err_cnt+1, go to HUNT, o_lock=0.
- sof mid-chip (counter in 1..CHIP_WORDS-1) in PASS or DROP: the chip is aborted and err_cnt+1.
  - No wlast is issued; the downstream loop buffer commits only on wlast, so the partial chip is simply overwritten.
  - If the word is a start, it is handled as a start in the same cycle (address 0 of the new chip). Otherwise go to HUNT.
- Sync mismatch with sof=1 in HUNT: ignored, no error.
- The i_tready decision is taken only at a start. A deassert mid-chip does not stop the burst.
- AGC/shift: in PASS, a valid word at AGC_IDX loads o_fft_agc with data[15:0], and a valid word at SHIFT_IDX loads o_fft_shift with data.
  - Both hold until the next accepted chip, so they are stable from address SHIFT_IDX+1 onward, including the downstream sample point at address 7.
  - Dropped chips do not update them.
- All counters saturate at 16'hFFFF.

## Timing
- Registered output, latency 1: a valid input word at cycle t appears on the o_cpri_* outputs at t+1.
- o_cpri_wen is high exactly one cycle per forwarded word. wdata, waddr and wlast are valid only while wen=1; outside that they are don't-care but must not toggle X.
- o_fft_agc and o_fft_shift update at t+1 after the capture word.
- o_lock, state and counters update on the cycle after the qualifying input.
- Reset values: every output is 0 and the state is HUNT. Reset asserted mid-chip aborts immediately with no wlast. Release is synchronous to wr_clk, so the first start is accepted on any cycle after deassertion.
- Simultaneous sof and word CHIP_WORDS-1 is impossible, because the counter is at 0 when sof is legal. Any sof at counter≥1 is the mid-chip case.

## Structure
- Shared package `cpri_rx_pkg`:
  - state enum `framer_st_e` {HUNT, PASS, DROP, WAIT_SOF}.
  - default constants CHIP_WORDS_DEF=96 and SYNC_WORD_DEF=16'hA5C3.
  - 16-bit counter type.
- One sub-module, `sat_cnt16`: 16-bit saturating counter with inc, async active-high reset. Instantiated three times.

## Test plan
- Lock and pass:
  - Stimulus: two back-to-back chips, word 0 = {16'hA5C3, 48'h0}, i_tready=1.
  - Response: 192 writes with waddr 0..95 twice, wlast at waddr 95 both times, chip_cnt=2, o_lock=1 one cycle after the first sof.
- Header extract:
  - Stimulus: word 1 = 64'h1234, word 2 = 64'hDEAD_BEEF_0000_0001.
  - Response: o_fft_agc=16'h1234 and o_fft_shift=64'hDEAD_BEEF_0000_0001, held through waddr 95.
- Back-pressure:
  - Stimulus: i_tready=0 at the second sof.
  - Response: no writes for that chip, drop_cnt=1, AGC and shift unchanged. Third chip with i_tready=1 is forwarded from waddr 0.
- Mid-chip sof:
  - Stimulus: a start at word 40.
  - Response: no wlast for the aborted chip, err_cnt=1, next write at waddr 0 on the following cycle.
- Sync loss:
  - Stimulus: after word 95, a valid word with sof=0.
  - Response: err_cnt+1, o_lock=0, no writes until the next start.
- Gaps and reset:
  - Stimulus: random vld gaps inside a chip, then wr_rst pulse at word 50.
  - Response: addresses contiguous despite gaps. After reset all outputs are 0, no wlast is issued, and relock occurs on the next start.

Source files
------------

// File: rtl/cpri_rx_pkg.sv
// cpri_rx_pkg: shared types and defaults for the CPRI receive chip framer.
package cpri_rx_pkg;
   typedef enum logic [1:0] {HUNT, PASS, DROP, WAIT_SOF} framer_st_e;
   localparam int CHIP_WORDS_DEF = 96;
   localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
   typedef logic [15:0] cnt16_t;
endpackage

// File: rtl/cpri_rx_framer_if.sv
// cpri_rx_framer_if: raw CPRI word input, chip write burst output and status of the framer.
interface cpri_rx_framer_if;
   import cpri_rx_pkg::*;
   logic [63:0] i_cpri_data;
   logic        i_cpri_vld;
   logic        i_cpri_sof;
   logic        i_tready;
   logic        o_cpri_wen;
   logic [6:0]  o_cpri_waddr;
   logic [63:0] o_cpri_wdata;
   logic        o_cpri_wlast;
   logic [15:0] o_fft_agc;
   logic [63:0] o_fft_shift;
   logic        o_lock;
   cnt16_t      o_chip_cnt;
   cnt16_t      o_drop_cnt;
   cnt16_t      o_err_cnt;
   modport master (
      output i_cpri_data, i_cpri_vld, i_cpri_sof, i_tready,
      input  o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast,
      input  o_fft_agc, o_fft_shift, o_lock, o_chip_cnt, o_drop_cnt, o_err_cnt
   );
   modport slave (
      input  i_cpri_data, i_cpri_vld, i_cpri_sof, i_tready,
      output o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast,
      output o_fft_agc, o_fft_shift, o_lock, o_chip_cnt, o_drop_cnt, o_err_cnt
   );
endinterface

// File: rtl/sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at all-ones.
module sat_cnt16
   import cpri_rx_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   inc_i,
   output cnt16_t cnt_o
);
   cnt16_t cnt_q, cnt_d;
   assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/cpri_rx_framer.sv
// cpri_rx_framer: hunts CPRI chip alignment and re-emits accepted chips as addressed write bursts,
// extracting FFT AGC/shift header fields and dropping whole chips when downstream is full.
module cpri_rx_framer
   import cpri_rx_pkg::*;
#(
   parameter int          CHIP_WORDS = CHIP_WORDS_DEF,
   parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEF,
   parameter int          AGC_IDX    = 1,
   parameter int          SHIFT_IDX  = 2
) (
   input logic             wr_clk,
   input logic             wr_rst,
   cpri_rx_framer_if.slave bus
);
   localparam logic [6:0] LAST_A  = 7'(CHIP_WORDS - 1);
   localparam logic [6:0] AGC_A   = 7'(AGC_IDX);
   localparam logic [6:0] SHIFT_A = 7'(SHIFT_IDX);

   framer_st_e  state_q, state_d;
   logic [6:0]  cnt_q, cnt_d, addr, waddr_q;
   logic [63:0] wdata_q, shift_q;
   logic [15:0] agc_q;
   logic        wen_q, wlast_q;
   logic        start, take, wr, last, inc_chip, inc_drop, inc_err;

   assign start = bus.i_cpri_vld && bus.i_cpri_sof && bus.i_cpri_data[63:48] == SYNC_WORD;

   // In PASS/DROP the counter is always >= 1, so any sof there is a mid-chip abort.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr     = cnt_q;
      take     = 1'b0;
      wr       = 1'b0;
      last     = 1'b0;
      inc_chip = 1'b0;
      inc_drop = 1'b0;
      inc_err  = 1'b0;
      if (bus.i_cpri_vld) begin
         case (state_q)
            HUNT: take = start;
            WAIT_SOF: begin
               take    = start;
               inc_err = !start;
               state_d = start ? state_q : HUNT;
            end
            default: begin
               if (bus.i_cpri_sof) begin
                  inc_err = 1'b1;
                  take    = start;
                  state_d = start ? state_q : HUNT;
                  cnt_d   = '0;
               end else begin
                  wr       = state_q == PASS;
                  last     = cnt_q == LAST_A;
                  inc_chip = wr && last;
                  state_d  = last ? WAIT_SOF : state_q;
                  cnt_d    = last ? '0 : cnt_q + 7'd1;
               end
            end
         endcase
         if (take) begin
            state_d  = bus.i_tready ? PASS : DROP;
            cnt_d    = 7'd1;
            addr     = '0;
            wr       = bus.i_tready;
            inc_drop = !bus.i_tready;
         end
      end
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         wlast_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         agc_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wr;
         wlast_q <= wr && last;
         if (wr) begin
            waddr_q <= addr;
            wdata_q <= bus.i_cpri_data;
         end
         if (wr && addr == AGC_A) agc_q <= bus.i_cpri_data[15:0];
         if (wr && addr == SHIFT_A) shift_q <= bus.i_cpri_data;
      end
   end

   sat_cnt16 u_chip_cnt (.clk(wr_clk), .rst(wr_rst), .inc_i(inc_chip), .cnt_o(bus.o_chip_cnt));
   sat_cnt16 u_drop_cnt (.clk(wr_clk), .rst(wr_rst), .inc_i(inc_drop), .cnt_o(bus.o_drop_cnt));
   sat_cnt16 u_err_cnt  (.clk(wr_clk), .rst(wr_rst), .inc_i(inc_err),  .cnt_o(bus.o_err_cnt));

   assign bus.o_cpri_wen   = wen_q;
   assign bus.o_cpri_waddr = waddr_q;
   assign bus.o_cpri_wdata = wdata_q;
   assign bus.o_cpri_wlast = wlast_q;
   assign bus.o_fft_agc    = agc_q;
   assign bus.o_fft_shift  = shift_q;
   assign bus.o_lock       = state_q != HUNT;
endmodule
